bsram_lsu_adapter: RTL
======================

Name: bsram_lsu_adapter

Overview:
- Sits directly upstream of the byte-enable flat BSRAM, between the core memory stage and the BRAM port.
- Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake.
- Drives the BRAM read/write/byte-enable port and returns aligned, extended load data through a small response FIFO.
- Flags and counts misaligned or illegal-size accesses; those requests never touch memory.

Parameters:
- CORE, 0, core index printed in scan output
- DATA_WIDTH, 32, BRAM word width; only 32 is supported
- ADDR_WIDTH, 8, BRAM word-address width
- RESP_DEPTH, 2, response FIFO entries; power of two, at least 2
- SCAN_CYCLES_MIN, 0, first cycle of scan $display window
- SCAN_CYCLES_MAX, 1000, last cycle of scan $display window

Ports:
- clock  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  adapter can accept the request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load (byte/half only)
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response at FIFO head
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  misaligned or illegal size
- err_count  out  16  saturating error counter
- readEnable  out  1  to BRAM
- readAddress  out  ADDR_WIDTH  to BRAM
- readData  in  32  from BRAM, same-cycle combinational
- writeEnable  out  1  to BRAM
- writeByteEnable  out  4  to BRAM
- writeAddress  out  ADDR_WIDTH  to BRAM
- writeData  out  32  to BRAM
- scan  in  1  enables $display trace inside the window

Behaviour:
- Handshake and accept:
  - req_ready = ~reset & (count < RESP_DEPTH). It has no combinational dependence on resp_ready.
  - accept = req_valid & req_ready.
- Address and lane:
  - Word address = req_addr[ADDR_WIDTH+1:2]; lane off = req_addr[1:0].
  - readAddress and writeAddress both carry the word address.
- Error: err = (size==11) | (size==01 & off[0]) | (size==10 & off!=0).
- BRAM drive (combinational in the accept cycle):
  - readEnable = accept & ~write & ~err.
  - writeEnable = accept & write & ~err.
  - All BRAM outputs are 0 when not enabled.
- Store byte enables and data:
  - byte: writeByteEnable = 0001<<off, writeData = {4{wdata[7:0]}}.
  - half: writeByteEnable = 0011<<off, writeData = {2{wdata[15:0]}}.
  - word: writeByteEnable = 1111, writeData = wdata.
- Load extraction:
  - Select lane from readData, then zero- or sign-extend per req_signed.
  - Word loads ignore req_signed.
  - The result is computed in the accept cycle and pushed into the FIFO.
- Response FIFO:
  - Each entry holds {rdata, error}.
  - Push on accept; pop on resp_valid & resp_ready.
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - resp_valid = (count != 0).
  - resp_rdata and resp_error show the head entry, and are 0 when empty.
- Latency and throughput:
  - Earliest response is 1 cycle after accept.
  - With RESP_DEPTH>=2 and resp_ready held high, the adapter sustains 1 request/cycle.
- Full FIFO:
  - req_ready=0 and no BRAM access.
  - A pop in that same cycle does not raise req_ready until the next cycle.
- Stores: a store produces a response with rdata=0 and error=0; the BRAM commits it at the same edge as the push.
- Load after store to the same word in the next cycle returns the new data. This needs no special logic.
- err_count increments on every accepted erroneous request and saturates at 16'hFFFF.
- Reset (async, effective immediately, including mid-stream):
  - count=0, pointers=0, err_count=0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready=0 and all BRAM enables 0.
  - In-flight responses are discarded.
- Scan: a cycle counter is cleared by reset. When scan is high inside the window, $display the request fields, BRAM port values, count and head response.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - a load-extract function (lane, size, signed → 32b);
  - a store-lane function (off, size → byte enable, replicated data).
- One sub-module, lsu_resp_fifo: parameterised synchronous FIFO, WIDTH=33, DEPTH=RESP_DEPTH, async active-high reset, count output.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x010, then word load 0x010 → writeByteEnable=1111, writeAddress=0x04; load response 0xDEADBEEF one cycle after accept.
- Byte store 0x80 to 0x013, then signed byte load 0x013 → BE=1000, writeData=0x80808080; response 0xFFFFFF80. The same load unsigned returns 0x00000080.
- Half load at 0x011 → no readEnable, resp_error=1, resp_rdata=0, err_count 0→1. Size 11 at 0x000 → err_count=2.
- Hold resp_ready=0 and issue 3 loads → first 2 accepted, req_ready=0 on the third. Raise resp_ready → responses drain in order, and the third is accepted the cycle after the first pop.
- Streaming 8 back-to-back loads with resp_ready=1 → req_ready stays 1, responses on 8 consecutive cycles.
- Assert reset with 2 responses queued → resp_valid drops immediately, err_count=0. After release, the next load responds normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the BSRAM load/store adapter:
// access size encodings, response entry layout and lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } lsu_size_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } st_lane_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

    // Shift the addressed lane down to bit 0, then extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: r = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replicating the data lets the byte enables alone pick the lane.
    function automatic st_lane_t store_lane(
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        st_lane_t r;
        case (size)
            SZ_BYTE: begin
                r.be   = 4'b0001 << off;
                r.data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                r.be   = 4'b0011 << off;
                r.data = {2{wdata[15:0]}};
            end
            default: begin
                r.be   = 4'b1111;
                r.data = wdata;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// Small synchronous FIFO holding load/store responses.
// Head entry reads as zero while the FIFO is empty.
module lsu_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/bsram_lsu_adapter.sv
// Load/store adapter in front of a byte-enable BSRAM port:
// lane steering, extension, error flagging and a response FIFO.
module bsram_lsu_adapter
    import lsu_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int RESP_DEPTH      = 2,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [15:0]           err_count,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  writeEnable,
    output logic [3:0]            writeByteEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic                  scan
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;

    logic [CW-1:0]         count;
    logic                  accept;
    logic                  err;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            off;
    st_lane_t              lane;
    logic [31:0]           ld_data;
    resp_t                 push_ent;
    resp_t                 head;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [31:0]           cycle_q;

    assign req_ready = ~reset & (count < CW'(RESP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign word_addr = req_addr[ADDR_WIDTH+1:2];
    assign off       = req_addr[1:0];

    assign err = (req_size == SZ_BAD)
               | ((req_size == SZ_HALF) & off[0])
               | ((req_size == SZ_WORD) & (off != 2'b00));

    assign lane    = store_lane(off, req_size, req_wdata);
    assign ld_data = load_extract(readData, off, req_size, req_signed);

    assign readEnable  = accept & ~req_write & ~err;
    assign writeEnable = accept & req_write & ~err;

    assign readAddress     = readEnable  ? word_addr : '0;
    assign writeAddress    = writeEnable ? word_addr : '0;
    assign writeByteEnable = writeEnable ? lane.be   : '0;
    assign writeData       = writeEnable ? lane.data : '0;

    // Stores and faulted requests respond with zero data.
    assign push_ent.rdata = readEnable ? ld_data : '0;
    assign push_ent.error = err;

    assign pop = resp_valid & resp_ready;

    lsu_resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (accept),
        .wdata_i (push_ent),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    assign resp_valid = (count != '0);
    assign resp_rdata = head.rdata;
    assign resp_error = head.error;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && err && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
            cycle_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            cycle_q   <= cycle_q + 32'd1;
        end
    end

    assign err_count = err_cnt_q;

    // Simulation-only trace; synthesis discards the display.
    always_ff @(posedge clock) begin
        if (scan && (cycle_q >= 32'(SCAN_CYCLES_MIN))
                 && (cycle_q <= 32'(SCAN_CYCLES_MAX))) begin
            $display("lsu%0d c%0d v%b r%b w%b sz%0d s%b a%h wd%h | re%b ra%h rd%h we%b be%b wa%h wd%h | n%0d rv%b rr%h re%b",
                     CORE, cycle_q, req_valid, req_ready, req_write,
                     req_size, req_signed, req_addr, req_wdata,
                     readEnable, readAddress, readData, writeEnable,
                     writeByteEnable, writeAddress, writeData,
                     count, resp_valid, resp_rdata, resp_error);
        end
    end

endmodule
